// File: rtl/time_tag_generator.sv
// time_tag_generator
//   Time-tag source for the frontend stream. A cycle counter wraps every
//   PERIOD_LEN clocks. Each wrap, or each resync strobe, starts a new period.
//   At every period boundary the generator places one 128-bit tag in a
//   one-deep slot. The slot is offered over a valid/ready handshake.
//   If the consumer has not taken the previous tag by the time the next one
//   arrives, the old tag is overwritten rather than stalling the timer. The
//   number of overwritten tags is reported in the tag.
//
// Ports
//   clk          : sole clock
//   rst_n        : asynchronous active-low reset
//   module_id    : static module ID placed in the tag
//   sync_in      : one-cycle resync strobe; loads sync_period, restarts counter
//   sync_period  : period value loaded on sync_in
//   stall        : combinational mask on valid (does not block slot updates)
//   valid        : a tag is available
//   ready        : consumer accepts the tag when valid is high
//   tt           : tag word
//   counter      : cycle index within the current period
//   period       : current period number
//   period_done  : one-cycle pulse in the first cycle of a new period
module time_tag_generator #(
  parameter int          PERIOD_LEN    = 100000,
  parameter int          COUNTER_WIDTH = 17,
  parameter int          PERIOD_WIDTH  = 48,
  parameter logic [1:0]  BLOCK_ID      = 2'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               module_id,
  input  logic                     sync_in,
  input  logic [PERIOD_WIDTH-1:0]  sync_period,
  input  logic                     stall,
  output logic                     valid,
  input  logic                     ready,
  output logic [127:0]             tt,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic [PERIOD_WIDTH-1:0]  period,
  output logic                     period_done
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(PERIOD_LEN - 1);

  // Set when the period that just started was entered through sync_in.
  logic boundary_sync;

  // Cleared by reset; its first rising edge produces the start-up tag.
  logic started;

  // Tag slot.
  logic                    pending;
  logic [PERIOD_WIDTH-1:0] tag_period;
  logic [7:0]              missed;
  logic                    rsync;

  logic ack;
  logic load;

  assign valid = pending & ~stall;
  assign ack   = valid & ready;
  assign load  = period_done | ~started;

  // Timer. A resync takes priority over a natural wrap in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter       <= '0;
      period        <= '0;
      period_done   <= 1'b0;
      boundary_sync <= 1'b0;
    end else if (sync_in) begin
      counter       <= '0;
      period        <= sync_period;
      period_done   <= 1'b1;
      boundary_sync <= 1'b1;
    end else if (counter == LAST_COUNT) begin
      counter       <= '0;
      period        <= period + PERIOD_WIDTH'(1);
      period_done   <= 1'b1;
      boundary_sync <= 1'b0;
    end else begin
      counter       <= counter + COUNTER_WIDTH'(1);
      period_done   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Slot update. A tag that is being acked this cycle counts as consumed, so
  // a coincident load starts a fresh tag rather than an overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      tag_period <= '0;
      missed     <= '0;
      rsync      <= 1'b0;
    end else if (load) begin
      pending    <= 1'b1;
      tag_period <= period;
      if (!pending || ack) begin
        missed <= '0;
        rsync  <= boundary_sync;
      end else begin
        missed <= (missed == 8'hFF) ? 8'hFF : missed + 8'd1;
        rsync  <= rsync | boundary_sync;
      end
    end else if (ack) begin
      pending <= 1'b0;
    end
  end

  assign tt = {5'b11111, 1'b0, module_id, BLOCK_ID, 1'b0, 58'b0,
               missed, rsync, 48'(tag_period)};

endmodule
